pipe_control_unit: RTL and testbench
====================================

Name: pipe_control_unit

Overview:
- Parametrised successor to the single-cycle opcode decoder, for the 5-stage RV32I pipeline.
- Decodes the ID-stage opcode into full control: ALU, memory, writeback and branch.
- Carries that control through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards (stall plus bubble insertion) and produces EX-stage forwarding selects.

Parameters:
- OP_W, 7, opcode width.
- RA_W, 5, register-address width; address 0 is hardwired zero.
- ALUOP_W, 2, ALUOp width; the encodings below are zero-extended if wider.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- Op_i  input  OP_W  opcode of the instruction in ID.
- rs1_i  input  RA_W  rs1 of the ID instruction.
- rs2_i  input  RA_W  rs2 of the ID instruction.
- rd_i  input  RA_W  rd of the ID instruction.
- flush_i  input  1  discard the ID instruction (redirect).
- stall_o  output  1  load-use stall; holds PC and IF/ID.
- Branch_o  output  1  ID-stage branch decode (combinational).
- ALUOp_o  output  ALUOP_W  EX-stage ALUOp.
- ALUSrc_o  output  1  EX-stage immediate select.
- FwdA_o  output  2  EX-stage rs1 forward select.
- FwdB_o  output  2  EX-stage rs2 forward select.
- MemRead_o  output  1  MEM-stage load enable.
- MemWrite_o  output  1  MEM-stage store enable.
- RegWrite_o  output  1  WB-stage register write.
- MemtoReg_o  output  1  WB-stage select: load data vs ALU result.
- rd_wb_o  output  RA_W  WB-stage destination register.

Behaviour:
- Decode (combinational, ID stage), fields listed as ALUOp / ALUSrc / RegWrite / MemRead / MemWrite / MemtoReg / Branch:
  - 0110011 R-type: 10/0/1/0/0/0/0.
  - 0010011 I-type: 11/1/1/0/0/0/0.
  - 0000011 load: 00/1/1/1/0/1/0.
  - 0100011 store: 00/1/0/0/1/0/0.
  - 1100011 branch: 01/0/0/0/0/0/1.
  - Any other opcode, including all-zero: every field 0 (bubble). Unknown opcodes are NOT treated as R-type.
- Register usage:
  - uses_rs1 = 1 for R, I, load, store and branch.
  - uses_rs2 = 1 for R, store and branch only.
- Pipeline registers, updated on rising clk_i:
  - ID/EX holds the decoded fields plus rs1, rs2, rd.
  - EX/MEM holds MemRead, MemWrite, RegWrite, MemtoReg, rd.
  - MEM/WB holds RegWrite, MemtoReg, rd.
- Latency: an instruction decoded in ID in cycle n drives EX outputs in n+1, MEM outputs in n+2 and WB outputs in n+3.
- Load-use stall (combinational):
  - stall_o = MemRead_ex & (rd_ex != 0) & ((uses_rs1 & rd_ex == rs1_i) | (uses_rs2 & rd_ex == rs2_i)) & ~flush_i.
- Bubble insertion: when stall_o or flush_i is 1, ID/EX loads all-zero control and rd = 0. EX/MEM and MEM/WB always advance.
- stall_o is high for exactly one cycle per load-use pair, because the next cycle EX holds the bubble.
- Simultaneous flush_i and a stall condition: flush wins, stall_o = 0, bubble inserted.
- Forwarding (combinational from registered state), FwdA shown; FwdB is identical using rs2_ex:
  - 10 if RegWrite_mem & rd_mem != 0 & rd_mem == rs1_ex.
  - else 01 if RegWrite_wb & rd_wb != 0 & rd_wb == rs1_ex.
  - else 00.
  - MEM has priority over WB.
- Register address 0 never produces a forward or a stall.
- Reset: rst_i low clears all three pipeline registers immediately, without waiting for a clock edge. All registered outputs read 0 and FwdA_o/FwdB_o read 00. stall_o reads 0 unless ID holds a matching opcode, which is impossible while EX is cleared.
- Reset asserted mid-stall drops the stall and the in-flight instructions; there is no replay.

Test Plan:
- Reset: assert rst_i low between clock edges -> all outputs 0 within the same cycle. Release, hold Op_i = 0 -> outputs remain 0.
- Decode latency: drive R, I, load, store, branch on consecutive cycles -> ALUOp_o sequence 10, 11, 00, 00, 01 starting one cycle later. MemWrite_o = 1 exactly 2 cycles after the store. Branch_o = 1 in the same cycle as the branch.
- Load-use: lw x5 then add x6, x5, x7 -> stall_o = 1 for one cycle, ALUOp_o = 00 (bubble) in the next cycle. With a load to x0, or an I-type whose rs2 field = 5 (rs2 unused) -> stall_o = 0.
- Forwarding:
  - add x1; add x2, x1, x1 -> FwdA_o = FwdB_o = 10.
  - Separated by one unrelated instruction -> 01.
  - x1 written in both MEM and WB -> 10.
- Flush priority: flush_i = 1 during a load-use condition -> stall_o = 0. The next cycle shows all EX/MEM/WB control = 0 for that slot.
- Unknown opcode 1111111 -> all controls 0, RegWrite_o = 0 three cycles later, no stall.

Source files
------------

// File: rtl/pipe_control_unit.sv
// Control path for a 5-stage RV32I pipeline. The ID-stage opcode is decoded
// into ALU, memory, writeback and branch control, then carried through the
// ID/EX, EX/MEM and MEM/WB control registers. The block also detects
// load-use hazards, inserting a single bubble into EX, and produces the
// EX-stage operand forwarding selects from the MEM and WB stage state.
module pipe_control_unit #(
  parameter int OP_W    = 7,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    Op_i,
  input  logic [RA_W-1:0]    rs1_i,
  input  logic [RA_W-1:0]    rs2_i,
  input  logic [RA_W-1:0]    rd_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               Branch_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               ALUSrc_o,
  output logic [1:0]         FwdA_o,
  output logic [1:0]         FwdB_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               RegWrite_o,
  output logic               MemtoReg_o,
  output logic [RA_W-1:0]    rd_wb_o
);

  // RV32I major opcodes recognised by the decoder
  localparam logic [OP_W-1:0] OP_RTYPE  = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_ITYPE  = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_STORE  = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(7'b1100011);

  // ALUOp encodings, zero-extended to the configured width
  localparam logic [ALUOP_W-1:0] ALU_ADD    = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_BRANCH = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_RTYPE  = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_ITYPE  = ALUOP_W'(2'b11);

  localparam logic [RA_W-1:0] REG_ZERO = RA_W'(0);

  // Forward select encodings
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // Forward select for one EX source operand; MEM is younger so it wins over WB,
  // and x0 never forwards because it is hardwired to zero.
  function automatic logic [1:0] fwd_sel(
    input logic            rw_mem,
    input logic [RA_W-1:0] rd_mem,
    input logic            rw_wb,
    input logic [RA_W-1:0] rd_wb,
    input logic [RA_W-1:0] rs
  );
    logic [1:0] sel;
    if (rw_mem && (rd_mem != REG_ZERO) && (rd_mem == rs)) begin
      sel = FWD_MEM;
    end else if (rw_wb && (rd_wb != REG_ZERO) && (rd_wb == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

  // ID-stage decode results
  logic [ALUOP_W-1:0] dec_aluop_s;
  logic               dec_alusrc_s;
  logic               dec_regwrite_s;
  logic               dec_memread_s;
  logic               dec_memwrite_s;
  logic               dec_memtoreg_s;
  logic               dec_branch_s;
  logic               dec_uses_rs1_s;
  logic               dec_uses_rs2_s;

  // ID/EX control register
  logic [ALUOP_W-1:0] aluop_ex_q,    aluop_ex_d;
  logic               alusrc_ex_q,   alusrc_ex_d;
  logic               regwrite_ex_q, regwrite_ex_d;
  logic               memread_ex_q,  memread_ex_d;
  logic               memwrite_ex_q, memwrite_ex_d;
  logic               memtoreg_ex_q, memtoreg_ex_d;
  logic [RA_W-1:0]    rs1_ex_q,      rs1_ex_d;
  logic [RA_W-1:0]    rs2_ex_q,      rs2_ex_d;
  logic [RA_W-1:0]    rd_ex_q,       rd_ex_d;

  // EX/MEM control register
  logic               memread_mem_q;
  logic               memwrite_mem_q;
  logic               regwrite_mem_q;
  logic               memtoreg_mem_q;
  logic [RA_W-1:0]    rd_mem_q;

  // MEM/WB control register
  logic               regwrite_wb_q;
  logic               memtoreg_wb_q;
  logic [RA_W-1:0]    rd_wb_q;

  logic               hazard_s;
  logic               stall_s;
  logic               bubble_s;

  // Decode the ID opcode; anything unrecognised decodes to an all-zero bubble
  always_comb begin
    dec_aluop_s    = ALU_ADD;
    dec_alusrc_s   = 1'b0;
    dec_regwrite_s = 1'b0;
    dec_memread_s  = 1'b0;
    dec_memwrite_s = 1'b0;
    dec_memtoreg_s = 1'b0;
    dec_branch_s   = 1'b0;
    dec_uses_rs1_s = 1'b0;
    dec_uses_rs2_s = 1'b0;
    case (Op_i)
      OP_RTYPE: begin
        dec_aluop_s    = ALU_RTYPE;
        dec_regwrite_s = 1'b1;
        dec_uses_rs1_s = 1'b1;
        dec_uses_rs2_s = 1'b1;
      end
      OP_ITYPE: begin
        dec_aluop_s    = ALU_ITYPE;
        dec_alusrc_s   = 1'b1;
        dec_regwrite_s = 1'b1;
        dec_uses_rs1_s = 1'b1;
      end
      OP_LOAD: begin
        dec_aluop_s    = ALU_ADD;
        dec_alusrc_s   = 1'b1;
        dec_regwrite_s = 1'b1;
        dec_memread_s  = 1'b1;
        dec_memtoreg_s = 1'b1;
        dec_uses_rs1_s = 1'b1;
      end
      OP_STORE: begin
        dec_aluop_s    = ALU_ADD;
        dec_alusrc_s   = 1'b1;
        dec_memwrite_s = 1'b1;
        dec_uses_rs1_s = 1'b1;
        dec_uses_rs2_s = 1'b1;
      end
      OP_BRANCH: begin
        dec_aluop_s    = ALU_BRANCH;
        dec_branch_s   = 1'b1;
        dec_uses_rs1_s = 1'b1;
        dec_uses_rs2_s = 1'b1;
      end
      default: begin
        dec_aluop_s    = ALU_ADD;
        dec_alusrc_s   = 1'b0;
        dec_regwrite_s = 1'b0;
        dec_memread_s  = 1'b0;
        dec_memwrite_s = 1'b0;
        dec_memtoreg_s = 1'b0;
        dec_branch_s   = 1'b0;
        dec_uses_rs1_s = 1'b0;
        dec_uses_rs2_s = 1'b0;
      end
    endcase
  end

  // Load-use detection: the load in EX targets a source the ID instruction reads.
  // A flush discards the ID instruction, so it suppresses the stall.
  always_comb begin
    hazard_s = memread_ex_q && (rd_ex_q != REG_ZERO) &&
               ((dec_uses_rs1_s && (rd_ex_q == rs1_i)) ||
                (dec_uses_rs2_s && (rd_ex_q == rs2_i)));
    stall_s  = hazard_s && !flush_i;
    bubble_s = stall_s || flush_i;
  end

  // ID/EX next state: either the decoded instruction or an all-zero bubble
  always_comb begin
    aluop_ex_d    = dec_aluop_s;
    alusrc_ex_d   = dec_alusrc_s;
    regwrite_ex_d = dec_regwrite_s;
    memread_ex_d  = dec_memread_s;
    memwrite_ex_d = dec_memwrite_s;
    memtoreg_ex_d = dec_memtoreg_s;
    rs1_ex_d      = rs1_i;
    rs2_ex_d      = rs2_i;
    rd_ex_d       = rd_i;
    if (bubble_s) begin
      aluop_ex_d    = ALU_ADD;
      alusrc_ex_d   = 1'b0;
      regwrite_ex_d = 1'b0;
      memread_ex_d  = 1'b0;
      memwrite_ex_d = 1'b0;
      memtoreg_ex_d = 1'b0;
      rs1_ex_d      = REG_ZERO;
      rs2_ex_d      = REG_ZERO;
      rd_ex_d       = REG_ZERO;
    end else begin
      aluop_ex_d    = dec_aluop_s;
      alusrc_ex_d   = dec_alusrc_s;
      regwrite_ex_d = dec_regwrite_s;
      memread_ex_d  = dec_memread_s;
      memwrite_ex_d = dec_memwrite_s;
      memtoreg_ex_d = dec_memtoreg_s;
      rs1_ex_d      = rs1_i;
      rs2_ex_d      = rs2_i;
      rd_ex_d       = rd_i;
    end
  end

  // ID/EX register: reset clears it without waiting for a clock edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      aluop_ex_q    <= ALU_ADD;
      alusrc_ex_q   <= 1'b0;
      regwrite_ex_q <= 1'b0;
      memread_ex_q  <= 1'b0;
      memwrite_ex_q <= 1'b0;
      memtoreg_ex_q <= 1'b0;
      rs1_ex_q      <= REG_ZERO;
      rs2_ex_q      <= REG_ZERO;
      rd_ex_q       <= REG_ZERO;
    end else begin
      aluop_ex_q    <= aluop_ex_d;
      alusrc_ex_q   <= alusrc_ex_d;
      regwrite_ex_q <= regwrite_ex_d;
      memread_ex_q  <= memread_ex_d;
      memwrite_ex_q <= memwrite_ex_d;
      memtoreg_ex_q <= memtoreg_ex_d;
      rs1_ex_q      <= rs1_ex_d;
      rs2_ex_q      <= rs2_ex_d;
      rd_ex_q       <= rd_ex_d;
    end
  end

  // EX/MEM register: always advances, even while ID is stalled
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      memread_mem_q  <= 1'b0;
      memwrite_mem_q <= 1'b0;
      regwrite_mem_q <= 1'b0;
      memtoreg_mem_q <= 1'b0;
      rd_mem_q       <= REG_ZERO;
    end else begin
      memread_mem_q  <= memread_ex_q;
      memwrite_mem_q <= memwrite_ex_q;
      regwrite_mem_q <= regwrite_ex_q;
      memtoreg_mem_q <= memtoreg_ex_q;
      rd_mem_q       <= rd_ex_q;
    end
  end

  // MEM/WB register: always advances
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      regwrite_wb_q <= 1'b0;
      memtoreg_wb_q <= 1'b0;
      rd_wb_q       <= REG_ZERO;
    end else begin
      regwrite_wb_q <= regwrite_mem_q;
      memtoreg_wb_q <= memtoreg_mem_q;
      rd_wb_q       <= rd_mem_q;
    end
  end

  // Output mapping: stage-registered control plus combinational stall/branch/forwarding
  always_comb begin
    stall_o    = stall_s;
    Branch_o   = dec_branch_s;
    ALUOp_o    = aluop_ex_q;
    ALUSrc_o   = alusrc_ex_q;
    FwdA_o     = fwd_sel(regwrite_mem_q, rd_mem_q, regwrite_wb_q, rd_wb_q, rs1_ex_q);
    FwdB_o     = fwd_sel(regwrite_mem_q, rd_mem_q, regwrite_wb_q, rd_wb_q, rs2_ex_q);
    MemRead_o  = memread_mem_q;
    MemWrite_o = memwrite_mem_q;
    RegWrite_o = regwrite_wb_q;
    MemtoReg_o = memtoreg_wb_q;
    rd_wb_o    = rd_wb_q;
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit. Each stimulus cycle pushes the
// hand-computed output snapshot for that cycle into a scoreboard queue; a
// separate monitor pops and compares it against the DUT on the falling edge.
module tb_pipe_control_unit;

  localparam logic [6:0] OP_Z = 7'b0000000;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_X = 7'b1111111;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [6:0] Op_i = 7'd0;
  logic [4:0] rs1_i = 5'd0;
  logic [4:0] rs2_i = 5'd0;
  logic [4:0] rd_i = 5'd0;
  logic       flush_i = 1'b0;
  logic       stall_o;
  logic       Branch_o;
  logic [1:0] ALUOp_o;
  logic       ALUSrc_o;
  logic [1:0] FwdA_o;
  logic [1:0] FwdB_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       RegWrite_o;
  logic       MemtoReg_o;
  logic [4:0] rd_wb_o;

  typedef struct {
    int          id;
    logic [17:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   vec_id = 0;
  logic drain_req = 1'b0;
  logic prev_stall = 1'b0;

  pipe_control_unit #(.OP_W(7), .RA_W(5), .ALUOP_W(2)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .Op_i       (Op_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .rd_i       (rd_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .Branch_o   (Branch_o),
    .ALUOp_o    (ALUOp_o),
    .ALUSrc_o   (ALUSrc_o),
    .FwdA_o     (FwdA_o),
    .FwdB_o     (FwdB_o),
    .MemRead_o  (MemRead_o),
    .MemWrite_o (MemWrite_o),
    .RegWrite_o (RegWrite_o),
    .MemtoReg_o (MemtoReg_o),
    .rd_wb_o    (rd_wb_o)
  );

  always #5 clk_i = ~clk_i;

  // One cycle of stimulus: drive ID inputs just after the rising edge and
  // queue the outputs expected for this cycle.
  // Expected field order: stall, branch, aluop, alusrc, fwdA, fwdB,
  // memread, memwrite, regwrite, memtoreg, rd_wb.
  task automatic step(
    input logic       rst, input logic [6:0] op,
    input logic [4:0] a, input logic [4:0] b, input logic [4:0] d, input logic fl,
    input logic st, input logic br, input logic [1:0] alu, input logic src,
    input logic [1:0] fa, input logic [1:0] fb,
    input logic mr, input logic mw, input logic rw, input logic m2r,
    input logic [4:0] rdwb
  );
    sb_t e;
    @(posedge clk_i);
    #1;
    rst_i   = rst;
    Op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    rd_i    = d;
    flush_i = fl;
    e.id  = vec_id;
    e.exp = {st, br, alu, src, fa, fb, mr, mw, rw, m2r, rdwb};
    sb_q.push_back(e);
    vec_id++;
  endtask

  // Monitor: compare the oldest queued expectation on every falling edge,
  // then report once the driver is done and the queue has drained.
  initial begin : monitor
    sb_t         e;
    logic [17:0] act;
    forever begin
      @(negedge clk_i);
      if (sb_q.size() != 0) begin
        e   = sb_q.pop_front();
        act = {stall_o, Branch_o, ALUOp_o, ALUSrc_o, FwdA_o, FwdB_o,
               MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o, rd_wb_o};
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL vec%0d: got st=%b br=%b alu=%b src=%b fa=%b fb=%b mr=%b mw=%b rw=%b m2r=%b rd=%0d, expected st=%b br=%b alu=%b src=%b fa=%b fb=%b mr=%b mw=%b rw=%b m2r=%b rd=%0d",
                   e.id, act[17], act[16], act[15:14], act[13], act[12:11], act[10:9],
                   act[8], act[7], act[6], act[5], act[4:0],
                   e.exp[17], e.exp[16], e.exp[15:14], e.exp[13], e.exp[12:11], e.exp[10:9],
                   e.exp[8], e.exp[7], e.exp[6], e.exp[5], e.exp[4:0]);
        end
        n_checks++;
        if ((stall_o === 1'b1) && (prev_stall === 1'b1)) begin
          n_fail++;
          $display("FAIL vec%0d: stall_o=%b for a second consecutive cycle, expected 0", e.id, stall_o);
        end
        n_checks++;
        if ((FwdA_o !== 2'b00 && FwdA_o !== 2'b01 && FwdA_o !== 2'b10) ||
            (FwdB_o !== 2'b00 && FwdB_o !== 2'b01 && FwdB_o !== 2'b10)) begin
          n_fail++;
          $display("FAIL vec%0d: illegal forward select fa=%b fb=%b, expected 00/01/10", e.id, FwdA_o, FwdB_o);
        end
        prev_stall = stall_o;
      end else if (drain_req) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  initial begin : driver
    repeat (2) @(posedge clk_i);
    //   rst  op    rs1   rs2   rd    fl  | st br alu  src fa    fb    mr mw rw m2r rdwb
    // Out of reset with a null opcode: everything stays zero
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    // Decode and stage latency: R, I, load, store, branch back to back
    step(1'b1, OP_R, 5'd1,  5'd2,  5'd3,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_I, 5'd4,  5'd0,  5'd8,  1'b0, 1'b0,1'b0,2'd2,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_L, 5'd9,  5'd0,  5'd10, 1'b0, 1'b0,1'b0,2'd3,1'b1,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_S, 5'd11, 5'd12, 5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b1,2'd0,2'd0,1'b0,1'b0,1'b1,1'b0,5'd3);
    step(1'b1, OP_B, 5'd14, 5'd15, 5'd0,  1'b0, 1'b0,1'b1,2'd0,1'b1,2'd0,2'd0,1'b1,1'b0,1'b1,1'b0,5'd8);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd1,1'b0,2'd0,2'd0,1'b0,1'b1,1'b1,1'b1,5'd10);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    // Load-use: lw x5 ; add x6,x5,x7 held in ID across the stall
    step(1'b1, OP_L, 5'd1,  5'd0,  5'd5,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_R, 5'd5,  5'd7,  5'd6,  1'b0, 1'b1,1'b0,2'd0,1'b1,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_R, 5'd5,  5'd7,  5'd6,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b1,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd2,1'b0,2'd1,2'd0,1'b0,1'b0,1'b1,1'b1,5'd5);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b1,1'b0,5'd6);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    // No stall: load to x0, then an I-type whose unused rs2 field matches
    step(1'b1, OP_L, 5'd1,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_R, 5'd0,  5'd0,  5'd6,  1'b0, 1'b0,1'b0,2'd0,1'b1,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_L, 5'd1,  5'd0,  5'd5,  1'b0, 1'b0,1'b0,2'd2,1'b0,2'd0,2'd0,1'b1,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_I, 5'd2,  5'd5,  5'd9,  1'b0, 1'b0,1'b0,2'd0,1'b1,2'd0,2'd0,1'b0,1'b0,1'b1,1'b1,5'd0);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd3,1'b1,2'd0,2'd2,1'b1,1'b0,1'b1,1'b0,5'd6);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b1,1'b1,5'd5);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b1,1'b0,5'd9);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    // Forwarding: x1 written twice, add x2,x1,x1, unrelated, add x4,x2,x2
    step(1'b1, OP_R, 5'd0,  5'd0,  5'd1,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_R, 5'd0,  5'd0,  5'd1,  1'b0, 1'b0,1'b0,2'd2,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_R, 5'd1,  5'd1,  5'd2,  1'b0, 1'b0,1'b0,2'd2,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_R, 5'd0,  5'd0,  5'd3,  1'b0, 1'b0,1'b0,2'd2,1'b0,2'd2,2'd2,1'b0,1'b0,1'b1,1'b0,5'd1);
    step(1'b1, OP_R, 5'd2,  5'd2,  5'd4,  1'b0, 1'b0,1'b0,2'd2,1'b0,2'd0,2'd0,1'b0,1'b0,1'b1,1'b0,5'd1);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd2,1'b0,2'd1,2'd1,1'b0,1'b0,1'b1,1'b0,5'd2);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b1,1'b0,5'd3);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b1,1'b0,5'd4);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    // Flush during a load-use condition: no stall, dependent slot becomes a bubble
    step(1'b1, OP_L, 5'd0,  5'd0,  5'd5,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_R, 5'd5,  5'd0,  5'd6,  1'b1, 1'b0,1'b0,2'd0,1'b1,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b1,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b1,1'b1,5'd5);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    // Unknown opcode behind a load to x5: no stall, no control, RegWrite 0 in WB
    step(1'b1, OP_L, 5'd0,  5'd0,  5'd5,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_X, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b1,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd2,2'd2,1'b1,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b1,1'b1,5'd5);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    // Reset dropped between edges with a load-use pair in flight: cleared at once, no replay
    step(1'b1, OP_L, 5'd0,  5'd0,  5'd5,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b0, OP_R, 5'd5,  5'd0,  5'd6,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    step(1'b1, OP_Z, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,5'd0);
    drain_req = 1'b1;
    repeat (20) @(posedge clk_i);
    $display("FAIL drain: scoreboard still holds %0d entries, required 0", sb_q.size());
    $fatal(1, "scoreboard did not drain");
  end

endmodule
